// File: rtl/mousetrap_sync_source.sv
// -----------------------------------------------------------------------------
// mousetrap_sync_source
//
// Clocked producer that feeds the head of a mousetrap_Nbit asynchronous
// pipeline. Words arrive on a valid/ready port, are buffered in a small FIFO
// and are launched one at a time using 2-phase (transition) req/ack
// bundled-data signalling. The returning ack is brought into the clock domain
// through a two-flop synchroniser.
//
// Ports
//   clk       in   1           single clock
//   reset     in   1           synchronous, active-low reset
//   s_data    in   DATA_WIDTH  word from synchronous logic
//   s_valid   in   1           s_data valid
//   s_ready   out  1           FIFO not full (registered); accept = s_valid & s_ready
//   data_out  out  DATA_WIDTH  bundled data to the pipeline stage's data_in
//   req_out   out  1           2-phase request to the stage's req_in
//   ack_in    in   1           2-phase ack from the stage's ack_out (asynchronous)
//   busy      out  1           FIFO non-empty or a transfer outstanding
//   tx_count  out  16          completed transfers, saturating
//                              (present only when MT_SRC_STATS_EN is defined)
//
// Optional feature macro: MT_SRC_STATS_EN
// -----------------------------------------------------------------------------
module mousetrap_sync_source #(
    parameter int DATA_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_out,
    input  logic                  ack_in,
    output logic                  busy
`ifdef MT_SRC_STATS_EN
    ,
    output logic [15:0]           tx_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- storage
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wptr_reg, wptr_next;
    logic [AW:0]           rptr_reg, rptr_next;
    logic                  s_ready_reg;
    logic                  empty;
    logic                  full_next;
    logic                  push;

    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  req_out_reg;
    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  pop;
    logic                  load;
    logic                  req_toggle;
    logic                  xfer_done;

    // ------------------------------------------------------- ack synchroniser
    logic [1:0] ack_sync_reg;
    logic       ack_s;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack_sync
            logic stage_d;
            if (gi == 0) begin : g_first
                assign stage_d = ack_in;
            end else begin : g_rest
                assign stage_d = ack_sync_reg[gi-1];
            end
            always_ff @(posedge clk) begin
                if (!reset) ack_sync_reg[gi] <= 1'b0;
                else        ack_sync_reg[gi] <= stage_d;
            end
        end
    endgenerate

    assign ack_s = ack_sync_reg[1];

    // ------------------------------------------------------------------- FIFO
    // s_ready_reg always equals !full of the current pointers, so push can
    // never overflow even though it is not recomputed from s_valid.
    assign push      = s_valid & s_ready_reg;
    assign empty     = (wptr_reg == rptr_reg);
    assign wptr_next = wptr_reg + (AW+1)'(push);
    assign rptr_next = rptr_reg + (AW+1)'(pop);
    assign full_next = (wptr_next[AW] != rptr_next[AW]) &&
                       (wptr_next[AW-1:0] == rptr_next[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) mem[wptr_reg[AW-1:0]] <= s_data;
    end

    // -------------------------------------------------------- FSM next-state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        load       = 1'b0;
        req_toggle = 1'b0;
        xfer_done  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty && (ack_s == req_out_reg)) begin
                    load       = 1'b1;
                    pop        = 1'b1;
                    cnt_next   = CW'(SETUP_CYCLES - 1);
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    req_toggle = 1'b1;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_WAIT: begin
                if (ack_s == req_out_reg) begin
                    xfer_done  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- state update
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            s_ready_reg  <= 1'b0;
            data_out_reg <= '0;
            req_out_reg  <= 1'b0;
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
        end else begin
            wptr_reg    <= wptr_next;
            rptr_reg    <= rptr_next;
            s_ready_reg <= !full_next;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            // The FIFO head is read only here, so data_out moves only on the
            // IDLE->SETUP transition and is frozen for the whole handshake.
            if (load)       data_out_reg <= mem[rptr_reg[AW-1:0]];
            if (req_toggle) req_out_reg  <= ~req_out_reg;
        end
    end

`ifdef MT_SRC_STATS_EN
    logic [15:0] tx_count_reg;
    always_ff @(posedge clk) begin
        if (!reset)                                  tx_count_reg <= '0;
        else if (xfer_done && tx_count_reg != 16'hFFFF) tx_count_reg <= tx_count_reg + 16'd1;
    end
    assign tx_count = tx_count_reg;
`endif

    assign s_ready  = s_ready_reg;
    assign data_out = data_out_reg;
    assign req_out  = req_out_reg;
    assign busy     = !empty || (state_reg != ST_IDLE) || (ack_s != req_out_reg);

    // An ack transition arriving while no request is outstanding is a
    // protocol violation; completion logic ignores it, this flags it.
    a_no_spurious_ack: assert property (@(posedge clk) disable iff (!reset)
        !((ack_sync_reg[0] != ack_sync_reg[1]) && (ack_sync_reg[1] == req_out_reg)));

endmodule

// File: tb/tb_mousetrap_sync_source.sv
module tb_mousetrap_sync_source;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s_data = 4'h0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] data_out;
    logic       req_out;
    logic       ack_in = 1'b0;
    logic       busy;
`ifdef MT_SRC_STATS_EN
    logic [15:0] tx_count;
`endif

    mousetrap_sync_source #(
        .DATA_WIDTH(4), .FIFO_DEPTH(4), .SETUP_CYCLES(1)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_out(data_out), .req_out(req_out),
        .ack_in(ack_in), .busy(busy)
`ifdef MT_SRC_STATS_EN
        , .tx_count(tx_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [3:0] got_q[$];
    logic       req_q[$];
    int         hold_err = 0;
    int         setup_err = 0;

    bit stage_en = 1'b0;
    bit ack_rand = 1'b0;
    int ack_delay = 2;
    int ack_cnt = 0;

    // Pipeline-stage model: answers each req transition after ack_delay clocks.
    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            ack_in = 1'b0;
            ack_cnt = 0;
        end else if (stage_en && (req_out !== ack_in)) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                ack_in = req_out;
                ack_cnt = 0;
                if (ack_rand) ack_delay = $urandom_range(1, 5);
            end
        end
    end

    // Transfer monitor: logs each launched word and tracks bundling stability.
    initial begin
        logic       prev_req;
        logic [3:0] prev_data;
        prev_req = 1'b0;
        prev_data = 4'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (req_out !== prev_req) begin
                    got_q.push_back(data_out);
                    req_q.push_back(req_out);
                    $display("[%0t] launch data=%h req=%b", $time, data_out, req_out);
                    if (data_out !== prev_data) setup_err++;
                end else if ((req_out !== ack_in) && (data_out !== prev_data)) begin
                    hold_err++;
                end
            end
            prev_req = req_out;
            prev_data = data_out;
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        req_q.delete();
        hold_err = 0;
        setup_err = 0;
    endtask

    // Drives one word until accepted; called and returns at #1 after a posedge.
    task automatic push_word(input logic [3:0] d, input int limit, output bit ok);
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        for (int n = 0; n < limit; n++) begin
            if (s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", req_out); end
        total++; if (data_out !== 4'h0) begin bad++; $display("FAIL rst_data: got %h want 0", data_out); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_single();
        apply_reset();
        stage_en = 1'b1;
        ack_rand = 1'b0;
        ack_delay = 2;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", s_ready); end
        s_valid = 1'b1;
        s_data = 4'b0011;
        @(posedge clk);                 // accept edge
        #1 s_valid = 1'b0;
        @(negedge clk);
        total++; if (data_out !== 4'h0) begin bad++; $display("FAIL single_data_e1: got %h want 0", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_e1: got %b want 1", busy); end
        @(negedge clk);
        total++; if (data_out !== 4'b0011) begin bad++; $display("FAIL single_data_e2: got %h want 3", data_out); end
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL single_req_e2: got %b want 0", req_out); end
        @(negedge clk);
        total++; if (req_out !== 1'b1) begin bad++; $display("FAIL single_req_e3: got %b want 1", req_out); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_e6: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_e7: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        total++; if (req_out !== 1'b1) begin bad++; $display("FAIL single_req_hold: got %b want 1", req_out); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== 4'b0011) begin bad++; $display("FAIL single_word: got %h want 3", got_q[0]); end
        end
        total++; if (hold_err + setup_err != 0) begin bad++; $display("FAIL single_stable: got %0d want 0", hold_err + setup_err); end
    endtask

    task automatic test_stream();
        logic [3:0] words [4];
        logic       reqs [4];
        bit ok;
        words = '{4'b1010, 4'b1111, 4'b0101, 4'b0001};
        reqs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        stage_en = 1'b1;
        ack_rand = 1'b0;
        ack_delay = 2;
        for (int i = 0; i < 4; i++) begin
            push_word(words[i], 20, ok);
            total++; if (!ok) begin bad++; $display("FAIL stream_push%0d: got timeout want accept", i); end
        end
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_idle: got %b want 0", busy); end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL stream_count: got %0d want 4", got_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (got_q[i] !== words[i]) begin bad++; $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], words[i]); end
                total++; if (req_q[i] !== reqs[i]) begin bad++; $display("FAIL stream_req%0d: got %b want %b", i, req_q[i], reqs[i]); end
            end
        end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL stream_hold: got %0d want 0", hold_err); end
        total++; if (setup_err !== 0) begin bad++; $display("FAIL stream_setup: got %0d want 0", setup_err); end
    endtask

    task automatic test_backpressure();
        logic [3:0] words [6];
        bit ok;
        int ready_seen;
        words = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
        apply_reset();
        stage_en = 1'b0;
        ack_rand = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(words[i], 20, ok);
            total++; if (!ok) begin bad++; $display("FAIL bp_push%0d: got timeout want accept", i); end
        end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", s_ready); end
        s_valid = 1'b1;
        s_data = words[5];
        ready_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (s_ready !== 1'b0) ready_seen++;
        end
        total++; if (ready_seen != 0) begin bad++; $display("FAIL bp_hold: got %0d ready cycles want 0", ready_seen); end
        total++; if (req_out !== 1'b1) begin bad++; $display("FAIL bp_req: got %b want 1", req_out); end
        total++; if (data_out !== 4'h9) begin bad++; $display("FAIL bp_data: got %h want 9", data_out); end
        stage_en = 1'b1;
        ack_delay = 1;
        push_word(words[5], 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_push5: got timeout want accept"); end
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", busy); end
        total++; if (got_q.size() != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (got_q[i] !== words[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], words[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] exp;
        apply_reset();
        stage_en = 1'b1;
        ack_rand = 1'b1;
        ack_delay = $urandom_range(1, 5);
        for (int i = 0; i < 12; i++) begin
            exp = 4'(i);
            push_word(exp, 100, ok);
            total++; if (!ok) begin bad++; $display("FAIL wrap_push%0d: got timeout want accept", i); end
        end
        for (int i = 0; i < 600 && busy !== 1'b0; i++) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle: got %b want 0", busy); end
        total++; if (got_q.size() != 12) begin bad++; $display("FAIL wrap_count: got %0d want 12", got_q.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                exp = 4'(i);
                total++; if (got_q[i] !== exp) begin bad++; $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp); end
            end
        end
        total++; if (hold_err + setup_err != 0) begin bad++; $display("FAIL wrap_stable: got %0d want 0", hold_err + setup_err); end
`ifdef MT_SRC_STATS_EN
        total++; if (tx_count !== 16'd12) begin bad++; $display("FAIL wrap_tx_count: got %0d want 12", tx_count); end
`endif
        ack_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        stage_en = 1'b0;
        ack_rand = 1'b0;
        push_word(4'hC, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_push0: got timeout want accept"); end
        push_word(4'hD, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_push1: got timeout want accept"); end
        for (int i = 0; i < 20 && req_out !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        total++; if (req_out !== 1'b1) begin bad++; $display("FAIL rm_wait_req: got %b want 1", req_out); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (req_out !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", req_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b want 0", s_ready); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        req_q.delete();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy_after: got %b want 0", busy); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after: got %b want 1", s_ready); end
        stage_en = 1'b1;
        ack_delay = 2;
        push_word(4'hE, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL rm_push2: got timeout want accept"); end
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_idle: got %b want 0", busy); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL rm_count: got %0d want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== 4'hE) begin bad++; $display("FAIL rm_word: got %h want e", got_q[0]); end
            total++; if (req_q[0] !== 1'b1) begin bad++; $display("FAIL rm_req_dir: got %b want 1", req_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
